ifu_fetch_ctrl: RTL and testbench

- Sequences instruction fetch for the NPC front end.
- Owns the fetch PC and issues one request at a time to the instruction-memory port.
- Holds the returned instruction until decode accepts it, then advances PC by 4.
- Applies branch redirects at any point, discarding stale in-flight responses so decode never sees a wrong-path instruction.

---
 rtl/ifu_pkg.sv | 18 +
 rtl/ifu_pc_gen.sv | 41 ++++
 rtl/ifu_fetch_ctrl.sv | 139 +++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// ifu_pkg -- shared definitions for the instruction-fetch controller.
//   INST_W    : instruction width
//   PC_ENTRY  : fetch PC after reset
//   PC_INC    : sequential PC increment (one 32-bit instruction)
//   fetch_state_e : fetch sequencer states (request / wait for response / hold for decode)
package ifu_pkg;

   localparam int unsigned INST_W   = 32;
   localparam logic [63:0] PC_ENTRY = 64'h0000_0000_8000_0000;
   localparam int unsigned PC_INC   = 4;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_OUT  = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/ifu_pc_gen.sv
// ifu_pc_gen -- fetch PC register and next-PC selection.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset (pc -> PC_ENTRY)
//   sel_redirect  : load redirect_pc (wins over sel_inc)
//   sel_inc       : advance pc by PC_INC, wrapping modulo 2^WIDTH
//   redirect_pc   : redirect target
//   pc            : current fetch PC
module ifu_pc_gen #(
   parameter int unsigned      WIDTH    = 64,
   parameter logic [WIDTH-1:0] PC_ENTRY = WIDTH'(ifu_pkg::PC_ENTRY)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sel_redirect,
   input  logic             sel_inc,
   input  logic [WIDTH-1:0] redirect_pc,
   output logic [WIDTH-1:0] pc
);
   import ifu_pkg::*;

   logic [WIDTH-1:0] pc_reg;
   logic [WIDTH-1:0] pc_next;

   always_comb begin
      pc_next = pc_reg;
      if (sel_redirect)
         pc_next = redirect_pc;
      else if (sel_inc)
         pc_next = pc_reg + WIDTH'(PC_INC);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pc_reg <= PC_ENTRY;
      else
         pc_reg <= pc_next;
   end

   assign pc = pc_reg;

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl -- single-outstanding instruction fetch sequencer.
// Issues one imem request at pc, waits for its response, holds the
// instruction for decode, then advances pc by 4. A redirect has priority
// in every state; a response already in flight when a redirect arrives is
// dropped via the kill flag so decode never sees a wrong-path instruction.
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   redirect_valid, redirect_pc    : branch redirect
//   imem_req_valid/ready/addr      : request channel (addr = pc)
//   imem_rsp_valid/data            : response channel (one per accepted request)
//   inst_valid/ready, inst_pc/data : instruction handed to decode
//   pc                             : current fetch PC
//   inst_misalign                  : only with IFU_MISALIGN_CHECK_EN defined;
//                                    marks a non-fetched misaligned-PC entry
module ifu_fetch_ctrl #(
   parameter int unsigned       WIDTH    = 64,
   parameter int unsigned       INST_W   = ifu_pkg::INST_W,
   parameter logic [WIDTH-1:0]  PC_ENTRY = WIDTH'(ifu_pkg::PC_ENTRY)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_valid,
   input  logic [WIDTH-1:0]  redirect_pc,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [WIDTH-1:0]  imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [INST_W-1:0] imem_rsp_data,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [WIDTH-1:0]  inst_pc,
   output logic [INST_W-1:0] inst_data,
   output logic [WIDTH-1:0]  pc
`ifdef IFU_MISALIGN_CHECK_EN
   ,
   output logic              inst_misalign
`endif
);
   import ifu_pkg::*;

   fetch_state_e      state_reg;
   logic              kill_reg;
   logic [WIDTH-1:0]  inst_pc_reg;
   logic [INST_W-1:0] inst_data_reg;
   logic              sel_inc;
   logic              pc_ok;

`ifdef IFU_MISALIGN_CHECK_EN
   logic misalign_reg;
   assign pc_ok         = (pc[1:0] == 2'b00);
   assign inst_misalign = misalign_reg;
`else
   assign pc_ok = 1'b1;
`endif

   // Sequential advance only when decode takes the held instruction and
   // no redirect overrides it.
   assign sel_inc = (state_reg == ST_OUT) && !redirect_valid && inst_ready;

   ifu_pc_gen #(
      .WIDTH    (WIDTH),
      .PC_ENTRY (PC_ENTRY)
   ) u_pc_gen (
      .clk          (clk),
      .rst          (rst),
      .sel_redirect (redirect_valid),
      .sel_inc      (sel_inc),
      .redirect_pc  (redirect_pc),
      .pc           (pc)
   );

   // State resets to REQ, so the request strobe is also masked by rst to
   // stay quiet while reset is held.
   assign imem_req_valid = (state_reg == ST_REQ) && !rst && pc_ok;
   assign imem_req_addr  = pc;
   assign inst_valid     = (state_reg == ST_OUT) && !rst;
   assign inst_pc        = inst_pc_reg;
   assign inst_data      = inst_data_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= ST_REQ;
         kill_reg      <= 1'b0;
         inst_pc_reg   <= '0;
         inst_data_reg <= '0;
`ifdef IFU_MISALIGN_CHECK_EN
         misalign_reg  <= 1'b0;
`endif
      end else begin
         case (state_reg)
            ST_REQ: begin
               // A redirect cancels any same-cycle handshake; pc_gen loads the target.
               if (!redirect_valid) begin
                  if (!pc_ok) begin
`ifdef IFU_MISALIGN_CHECK_EN
                     state_reg     <= ST_OUT;
                     inst_pc_reg   <= pc;
                     inst_data_reg <= '0;
                     misalign_reg  <= 1'b1;
`endif
                  end else if (imem_req_ready) begin
                     state_reg <= ST_WAIT;
                     kill_reg  <= 1'b0;
                  end
               end
            end
            ST_WAIT: begin
               if (redirect_valid) begin
                  if (imem_rsp_valid) begin
                     kill_reg  <= 1'b0;
                     state_reg <= ST_REQ;
                  end else begin
                     // Response still in flight belongs to the old path.
                     kill_reg <= 1'b1;
                  end
               end else if (imem_rsp_valid) begin
                  if (kill_reg) begin
                     kill_reg  <= 1'b0;
                     state_reg <= ST_REQ;
                  end else begin
                     inst_data_reg <= imem_rsp_data;
                     inst_pc_reg   <= pc;
`ifdef IFU_MISALIGN_CHECK_EN
                     misalign_reg  <= 1'b0;
`endif
                     state_reg     <= ST_OUT;
                  end
               end
            end
            ST_OUT: begin
               if (redirect_valid || inst_ready)
                  state_reg <= ST_REQ;
            end
            default: state_reg <= ST_REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed, table-driven bench for ifu_fetch_ctrl. Each table row holds the
// inputs driven for one cycle and the outputs expected during that cycle.
module tb_ifu_fetch_ctrl;

   localparam logic [63:0] A0    = 64'h8000_0000;
   localparam logic [63:0] A4    = 64'h8000_0004;
   localparam logic [63:0] A8    = 64'h8000_0008;
   localparam logic [63:0] AC    = 64'h8000_000C;
   localparam logic [63:0] B1000 = 64'h8000_1000;
   localparam logic [63:0] B1004 = 64'h8000_1004;
   localparam logic [63:0] B2000 = 64'h8000_2000;
   localparam logic [63:0] B2004 = 64'h8000_2004;
   localparam logic [63:0] B3000 = 64'h8000_3000;
   localparam logic [63:0] TOP   = 64'hFFFF_FFFF_FFFF_FFFC;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [63:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [63:0] inst_pc;
   logic [31:0] inst_data;
   logic [63:0] pc;
`ifdef IFU_MISALIGN_CHECK_EN
   logic        inst_misalign;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ifu_fetch_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_pc        (inst_pc),
      .inst_data      (inst_data),
      .pc             (pc)
`ifdef IFU_MISALIGN_CHECK_EN
      ,
      .inst_misalign  (inst_misalign)
`endif
   );

   typedef struct {
      logic        rv;
      logic [63:0] rpc;
      logic        rdy;
      logic        rspv;
      logic [31:0] rspd;
      logic        irdy;
      logic        e_req;
      logic        e_iv;
      logic [63:0] e_ipc;
      logic [31:0] e_idata;
      logic [63:0] e_pc;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rv, input logic [63:0] rpc, input logic rdy,
                      input logic rspv, input logic [31:0] rspd, input logic irdy,
                      input logic e_req, input logic e_iv, input logic [63:0] e_ipc,
                      input logic [31:0] e_idata, input logic [63:0] e_pc);
      vec_t v;
      v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.rspv = rspv; v.rspd = rspd; v.irdy = irdy;
      v.e_req = e_req; v.e_iv = e_iv; v.e_ipc = e_ipc; v.e_idata = e_idata; v.e_pc = e_pc;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rv, input logic [63:0] rpc, input logic rdy,
                        input logic rspv, input logic [31:0] rspd, input logic irdy);
      redirect_valid = rv;
      redirect_pc    = rpc;
      imem_req_ready = rdy;
      imem_rsp_valid = rspv;
      imem_rsp_data  = rspd;
      inst_ready     = irdy;
   endtask

   initial begin
      // Sequential fetch, latency 1, decode always ready.
      add(0,0,1,0,0,1,            1,0, 0,0, A0);
      add(0,0,0,1,32'h13,1,       0,0, 0,0, A0);
      add(0,0,0,0,0,1,            0,1, A0,32'h13, A0);
      add(0,0,1,0,0,1,            1,0, A0,32'h13, A4);
      add(0,0,0,1,32'h13,1,       0,0, A0,32'h13, A4);
      add(0,0,0,0,0,1,            0,1, A4,32'h13, A4);
      add(0,0,1,0,0,1,            1,0, A4,32'h13, A8);
      add(0,0,0,1,32'h13,1,       0,0, A4,32'h13, A8);
      // Decode stall for 5 cycles; a stray response is ignored.
      add(0,0,1,0,0,0,            0,1, A8,32'h13, A8);
      add(0,0,1,0,0,0,            0,1, A8,32'h13, A8);
      add(0,0,1,1,32'hBAD0BAD0,0, 0,1, A8,32'h13, A8);
      add(0,0,1,0,0,0,            0,1, A8,32'h13, A8);
      add(0,0,1,0,0,0,            0,1, A8,32'h13, A8);
      add(0,0,0,0,0,1,            0,1, A8,32'h13, A8);
      // Memory not ready for one cycle.
      add(0,0,0,0,0,0,            1,0, A8,32'h13, AC);
      add(0,0,1,0,0,0,            1,0, A8,32'h13, AC);
      // Redirect in WAIT; stale response two cycles later.
      add(1,B1000,0,0,0,0,        0,0, A8,32'h13, AC);
      add(0,0,0,0,0,0,            0,0, A8,32'h13, B1000);
      add(0,0,0,1,32'hDEADBEEF,0, 0,0, A8,32'h13, B1000);
      add(0,0,1,0,0,0,            1,0, A8,32'h13, B1000);
      add(0,0,0,1,32'h00100093,0, 0,0, A8,32'h13, B1000);
      add(0,0,0,0,0,1,            0,1, B1000,32'h00100093, B1000);
      // Redirect coinciding with the response.
      add(0,0,1,0,0,0,            1,0, B1000,32'h00100093, B1004);
      add(1,B2000,0,1,32'h11111111,0, 0,0, B1000,32'h00100093, B1004);
      add(0,0,1,0,0,0,            1,0, B1000,32'h00100093, B2000);
      add(0,0,0,1,32'h22222222,0, 0,0, B1000,32'h00100093, B2000);
      // Redirect in OUT with decode ready: no +4.
      add(1,B2000,0,0,0,1,        0,1, B2000,32'h22222222, B2000);
      add(0,0,1,0,0,0,            1,0, B2000,32'h22222222, B2000);
      add(0,0,0,1,32'h33333333,0, 0,0, B2000,32'h22222222, B2000);
      add(0,0,0,0,0,1,            0,1, B2000,32'h33333333, B2000);
      // Redirect in REQ cancels the same-cycle handshake.
      add(1,B3000,1,0,0,0,        1,0, B2000,32'h33333333, B2004);
      add(0,0,0,0,0,0,            1,0, B2000,32'h33333333, B3000);
      // PC wrap at the top of the address space.
      add(1,TOP,0,0,0,0,          1,0, B2000,32'h33333333, B3000);
      add(0,0,1,0,0,0,            1,0, B2000,32'h33333333, TOP);
      add(0,0,0,1,32'h44444444,0, 0,0, B2000,32'h33333333, TOP);
      add(0,0,0,0,0,1,            0,1, TOP,32'h44444444, TOP);
      add(0,0,0,0,0,0,            1,0, TOP,32'h44444444, 64'h0);

      // Reset held across a clock edge: both strobes quiet.
      @(negedge clk);
      chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
      chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
      rst = 1'b0;
      #1;
      chk("first_req_valid", {63'd0, imem_req_valid}, 64'd1);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         chk($sformatf("v%0d_req_valid", i), {63'd0, imem_req_valid}, {63'd0, vecs[i].e_req});
         chk($sformatf("v%0d_inst_valid", i), {63'd0, inst_valid}, {63'd0, vecs[i].e_iv});
         chk($sformatf("v%0d_req_addr", i), imem_req_addr, vecs[i].e_pc);
         chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
         chk($sformatf("v%0d_inst_pc", i), inst_pc, vecs[i].e_ipc);
         chk($sformatf("v%0d_inst_data", i), {32'd0, inst_data}, {32'd0, vecs[i].e_idata});
`ifdef IFU_MISALIGN_CHECK_EN
         chk($sformatf("v%0d_misalign", i), {63'd0, inst_misalign}, 64'd0);
`endif
         $display("vec %0d: req=%b addr=%h inst_v=%b inst_pc=%h inst_data=%h",
                  i, imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst_data);
         drive(vecs[i].rv, vecs[i].rpc, vecs[i].rdy, vecs[i].rspv, vecs[i].rspd, vecs[i].irdy);
      end

      // Asynchronous reset mid-WAIT, late response after release.
      @(negedge clk);
      drive(0, 0, 1, 0, 0, 0);                 // REQ at 0 -> WAIT
      @(negedge clk);
      chk("ar_in_wait", {63'd0, imem_req_valid}, 64'd0);
      drive(0, 0, 0, 0, 0, 0);
      #2 rst = 1'b1;
      #1;
      chk("ar_pc_async", pc, A0);
      chk("ar_inst_pc_async", inst_pc, 64'd0);
      chk("ar_inst_data_async", {32'd0, inst_data}, 64'd0);
      chk("ar_req_valid_async", {63'd0, imem_req_valid}, 64'd0);
      $display("async reset: pc=%h inst_pc=%h", pc, inst_pc);
      @(negedge clk);
      chk("ar_req_valid_held", {63'd0, imem_req_valid}, 64'd0);
      rst = 1'b0;
      #1;
      chk("ar_restart_req", {63'd0, imem_req_valid}, 64'd1);
      chk("ar_restart_addr", imem_req_addr, A0);
      drive(0, 0, 0, 1, 32'hDEADDEAD, 0);      // late response while in REQ
      @(negedge clk);
      chk("ar_late_ignored_req", {63'd0, imem_req_valid}, 64'd1);
      chk("ar_late_ignored_iv", {63'd0, inst_valid}, 64'd0);
      drive(0, 0, 1, 0, 0, 0);
      @(negedge clk);
      drive(0, 0, 0, 1, 32'h55555555, 0);
      @(negedge clk);
      chk("ar_deliver_iv", {63'd0, inst_valid}, 64'd1);
      chk("ar_deliver_pc", inst_pc, A0);
      chk("ar_deliver_data", {32'd0, inst_data}, 64'h55555555);
      $display("restart: inst_v=%b inst_pc=%h inst_data=%h", inst_valid, inst_pc, inst_data);

`ifdef IFU_MISALIGN_CHECK_EN
      // Redirect to a misaligned target while handing off the held instruction.
      drive(1, 64'h8000_0002, 0, 0, 0, 1);
      @(negedge clk);
      chk("mis_no_req", {63'd0, imem_req_valid}, 64'd0);
      chk("mis_pc", pc, 64'h8000_0002);
      drive(0, 0, 1, 0, 0, 0);
      @(negedge clk);
      chk("mis_iv", {63'd0, inst_valid}, 64'd1);
      chk("mis_flag", {63'd0, inst_misalign}, 64'd1);
      chk("mis_inst_pc", inst_pc, 64'h8000_0002);
      chk("mis_inst_data", {32'd0, inst_data}, 64'd0);
      chk("mis_no_req_out", {63'd0, imem_req_valid}, 64'd0);
      $display("misalign: inst_v=%b mis=%b inst_pc=%h", inst_valid, inst_misalign, inst_pc);
`endif

      drive(0, 0, 0, 0, 0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
